// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the sequential Booth multiplier
package mul_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction
  localparam int CNT_W = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (add/sub of M, then arithmetic right shift of {A, Q, q_m1})
module booth_step import mul_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH+1:0] a_i,
  input  logic [WIDTH:0]   q_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH+1:0] a_o,
  output logic [WIDTH:0]   q_o,
  output logic             qm1_o
);
  booth_op_e op;
  logic [WIDTH+1:0] sum;
  always_comb begin
    op = {q_i[0], qm1_i} == 2'b01 ? ADD : {q_i[0], qm1_i} == 2'b10 ? SUB : NOP;
    sum = op == ADD ? a_i + {m_i[WIDTH], m_i} : op == SUB ? a_i - {m_i[WIDTH], m_i} : a_i;
    {a_o, q_o, qm1_o} = {sum[WIDTH+1], sum, q_i};
  end
endmodule

// File: rtl/seq_booth_mul.sv
// seq_booth_mul: multi-cycle signed/unsigned radix-2 Booth multiplier with start/busy/done handshake
module seq_booth_mul import mul_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  state_e state_q;
  logic [WIDTH:0] m_q, q_q, q_d;
  logic [WIDTH+1:0] a_q, a_d;
  logic qm1_q, qm1_d, busy_q, done_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i(a_q), .q_i(q_q), .qm1_i(qm1_q), .m_i(m_q),
    .a_o(a_d), .q_o(q_d), .qm1_o(qm1_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      q_q <= '0;
      a_q <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != RUN && start) begin
        state_q <= RUN;
        busy_q <= 1'b1;
        m_q <= {is_signed & a[WIDTH-1], a};
        q_q <= {is_signed & b[WIDTH-1], b};
        a_q <= '0;
        qm1_q <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_q <= a_d;
        q_q <= q_d;
        qm1_q <= qm1_d;
        cnt_q <= cnt_q + CW'(1);
        // WIDTH+1 steps cover the extended operand; the final step's output is the product
        if (cnt_q == CW'(WIDTH)) begin
          state_q <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          {hi_q, lo_q} <= PW'({a_d, q_d});
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_seq_booth_mul.sv
// tb_seq_booth_mul: randomized scoreboard bench for seq_booth_mul against an arithmetic product model
module tb_seq_booth_mul;
  localparam int W = 32;
  typedef struct {logic [63:0] p; int c;} exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [W-1:0] a = '0, b = '0, hi, lo;
  logic busy, done;
  int cyc = 0, ncmp = 0, nfail = 0, run = 0, prev_done = 0, last_gap = 0;
  exp_t exp_q[$];
  logic sv_s[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [W-1:0] sv_a[5] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
  logic [W-1:0] sv_b[5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd1};

  seq_booth_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(sx * sy);
  endfunction

  function automatic logic [W-1:0] pick();
    int r;
    r = int'($urandom_range(0, 7));
    return r == 0 ? 32'h0 : r == 1 ? 32'h80000000 : r == 2 ? 32'hFFFFFFFF : r == 3 ? 32'h1 : W'($urandom);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    ncmp++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    is_signed = s;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{model(s, x, y), cyc});
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst) run = 0;
    else begin
      if (busy && done) chk("busy_and_done", 64'(busy & done), 64'd0);
      if (busy) run++;
      if (done) begin
        last_gap = cyc - prev_done;
        prev_done = cyc;
        chk("busy_cycles", 64'(run), 64'd33);
        run = 0;
        if (exp_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", {hi, lo}, e.p);
          chk("latency", 64'(cyc - e.c), 64'd33);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {hi, lo}, 64'd0);
    chk("reset_flags", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      issue(sv_s[i], sv_a[i], sv_b[i]);
      wait_done();
    end
    // a second start in the middle of RUN must be ignored
    issue(1'b0, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (40) @(posedge clk);
    #1;
    // start held high: the next operands are presented during the DONE cycle
    is_signed = 1'b0;
    a = 32'd2;
    b = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{model(1'b0, 32'd2, 32'd4), cyc});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
    end
    a = 32'd6;
    b = 32'd7;
    @(posedge clk);
    #1;
    exp_q.push_back('{model(1'b0, 32'd6, 32'd7), cyc});
    start = 1'b0;
    wait_done();
    chk("b2b_gap", 64'(last_gap), 64'd34);
    issue(1'b1, 32'h12345678, 32'h9ABCDEF0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("abort_outputs", {hi, lo}, 64'd0);
    chk("abort_flags", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(1'b1, 32'hFFFFFFF0, 32'd100);
    wait_done();
    for (int i = 0; i < 40; i++) begin
      logic s;
      logic [W-1:0] x, y;
      s = 1'($urandom_range(0, 1));
      x = pick();
      y = pick();
      issue(s, x, y);
      wait_done();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
